// File: rtl/cc_pkg.sv
// Shared widths and the response entry layout for the CalculationCore scheduler.
package cc_pkg;
  localparam int CC_OP_W  = 512;
  localparam int CC_RES_W = 24;
  localparam int CC_ID_W  = 3;   // wide enough for the largest supported N_REQ (8)

  typedef struct packed {
    logic [CC_ID_W-1:0]  id;
    logic [CC_RES_W-1:0] data;
  } rsp_entry_t;
endpackage

// File: rtl/cc_rsp_fifo.sv
// Synchronous response FIFO, first-word fall-through with a registered head.
module cc_rsp_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic             do_pop, do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_nxt  = rd_ptr + AW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_nxt;
      count  <= count + CW'(do_push) - CW'(do_pop);
      // A push into a FIFO that is (or becomes) empty lands straight in the head
      dout   <= (do_push && count == CW'(do_pop)) ? din : mem[rd_nxt];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !do_pop));
endmodule

// File: rtl/cc_scheduler.sv
// Round-robin scheduler sharing one fixed-latency CalculationCore among N_REQ
// requesters, with tag tracking and a credit-protected response FIFO.
module cc_scheduler
  import cc_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int CORE_LAT  = 4,
  parameter int RSP_DEPTH = 8,
  parameter int ID_W      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*CC_OP_W-1:0] req_a,
  input  logic [N_REQ*CC_OP_W-1:0] req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [CC_OP_W-1:0]       cc_a,
  output logic [CC_OP_W-1:0]       cc_b,
  input  logic [CC_RES_W-1:0]      cc_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [CC_RES_W-1:0]      rsp_data,
  output logic                     busy
);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic                       rdy_en;
  logic [ID_W-1:0]            ptr, winner, tag_id;
  logic                       grant_any, issue_ok, retire;
  logic [CW-1:0]              inflight, fifo_count;
  logic                       fifo_full, fifo_empty;
  logic [CORE_LAT:0]          vld_pipe;
  logic [CORE_LAT:0][ID_W-1:0] id_pipe;
  rsp_entry_t                 push_entry, head;
  int                         idx;

  // Conservative credit: a pop in this cycle is not counted as a free slot
  assign issue_ok = rdy_en && ((fifo_count + inflight) < CW'(RSP_DEPTH));

  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    req_ready = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (issue_ok && !grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        winner    = ID_W'(idx);
      end
    end
    if (grant_any) req_ready[winner] = 1'b1;
  end

  assign tag_id = grant_any ? winner : '0;
  // Stage 0 lines up with cc_a/cc_b; stage CORE_LAT lines up with cc_out
  assign retire = vld_pipe[CORE_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en   <= 1'b0;
      ptr      <= '0;
      cc_a     <= '0;
      cc_b     <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
      inflight <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (grant_any) ptr <= (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
      cc_a     <= grant_any ? req_a[winner*CC_OP_W +: CC_OP_W] : '0;
      cc_b     <= grant_any ? req_b[winner*CC_OP_W +: CC_OP_W] : '0;
      vld_pipe <= {vld_pipe[CORE_LAT-1:0], grant_any};
      id_pipe  <= {id_pipe[CORE_LAT-1:0], tag_id};
      if (grant_any && !retire)      inflight <= inflight + 1'b1;
      else if (!grant_any && retire) inflight <= inflight - 1'b1;
    end
  end

  assign push_entry.id   = CC_ID_W'(id_pipe[CORE_LAT]);
  assign push_entry.data = cc_out;

  cc_rsp_fifo #(
    .WIDTH($bits(rsp_entry_t)),
    .DEPTH(RSP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (retire),
    .din   (push_entry),
    .pop   (rsp_ready),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_id    = head.id[ID_W-1:0];
  assign rsp_data  = head.data;
  assign busy      = (inflight != '0) || (fifo_count != '0);

  a_credit: assert property (@(posedge clk) disable iff (!rst_n) fifo_full |-> inflight == '0);
  a_head_id: assert property (@(posedge clk) disable iff (!rst_n) !rsp_valid || head.id < CC_ID_W'(N_REQ));
endmodule

// File: tb/tb_cc_scheduler.sv
// Directed bench for cc_scheduler with a stub core returning A[23:0]+B[23:0].
module tb_cc_scheduler;
  localparam int N = 4, LAT = 4, DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*512-1:0] req_a, req_b;
  logic [N-1:0]     req_ready;
  logic [511:0]     cc_a, cc_b;
  logic [23:0]      cc_out;
  logic             rsp_valid, rsp_ready;
  logic [1:0]       rsp_id;
  logic [23:0]      rsp_data;
  logic             busy;

  always #5 clk = ~clk;

  cc_scheduler #(.N_REQ(N), .CORE_LAT(LAT), .RSP_DEPTH(DEPTH), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .cc_a(cc_a), .cc_b(cc_b), .cc_out(cc_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  // Stub core: operands in cycle c give the sum on cc_out in cycle c+LAT
  logic [23:0] stub_pipe [LAT];
  always @(posedge clk) begin
    stub_pipe[0] <= cc_a[23:0] + cc_b[23:0];
    for (int k = 1; k < LAT; k++) stub_pipe[k] <= stub_pipe[k-1];
  end
  assign cc_out = stub_pipe[LAT-1];

  typedef struct packed { logic [1:0] id; logic [23:0] data; } exp_t;
  typedef struct { logic [3:0] valid; logic [3:0] ready; } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*512 +: 512] = 512'(i + 1);
      req_b[i*512 +: 512] = '0;
    end
  endtask

  task automatic push_exp(input int id);
    exp_q.push_back(exp_t'{id: 2'(id), data: 24'(id + 1)});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Response scoreboard: every pop must match the next expected entry
  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1 && rsp_valid && rsp_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d data=%0h, none expected", rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vecs [12];
  int   k, g;

  initial begin
    rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b0; set_ops();
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_cc_a", 64'(cc_a != '0), 0);
    chk("rst_cc_b", 64'(cc_b != '0), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_id", 64'(rsp_id), 0);
    chk("rst_rsp_data", 64'(rsp_data), 0);
    chk("rst_busy", 64'(busy), 0);

    // 1. single request from requester 2
    do_reset();
    rsp_ready = 1'b1;
    req_a[2*512 +: 512] = 512'h5;
    req_b[2*512 +: 512] = 512'h3;
    @(negedge clk); req_valid = 4'b0100; #1;
    chk("t1_ready", 64'(req_ready), 64'h4);
    exp_q.push_back(exp_t'{id: 2'd2, data: 24'h000008});
    @(negedge clk); req_valid = '0; #1;
    chk("t1_cc_a", cc_a[63:0], 64'h5);
    chk("t1_cc_a_hi", 64'(cc_a[511:64] != '0), 0);
    chk("t1_cc_b", cc_b[63:0], 64'h3);
    chk("t1_busy_c1", 64'(busy), 1);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) begin @(negedge clk); #1; end
      chk("t1_no_rsp_early", 64'(rsp_valid), 0);
    end
    @(negedge clk); #1;
    chk("t1_rsp_valid_c6", 64'(rsp_valid), 1);
    chk("t1_rsp_id", 64'(rsp_id), 2);
    chk("t1_rsp_data", 64'(rsp_data), 64'h8);
    chk("t1_busy_c6", 64'(busy), 1);
    @(negedge clk); #1;
    chk("t1_busy_c7", 64'(busy), 0);
    chk("t1_rsp_valid_c7", 64'(rsp_valid), 0);
    set_ops();

    // 2. arbitration table, pointer starts at 0 after reset
    vecs[0]  = '{4'b1111, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0001};
    vecs[5]  = '{4'b0001, 4'b0001};
    vecs[6]  = '{4'b1100, 4'b0100};
    vecs[7]  = '{4'b0110, 4'b0010};
    vecs[8]  = '{4'b0000, 4'b0000};
    vecs[9]  = '{4'b1001, 4'b1000};
    vecs[10] = '{4'b1010, 4'b0010};
    vecs[11] = '{4'b0101, 4'b0100};
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); req_valid = vecs[i].valid; #1;
      chk($sformatf("t2_ready[%0d]", i), 64'(req_ready), 64'(vecs[i].ready));
      for (int j = 0; j < N; j++) if (vecs[i].ready[j]) push_exp(j);
    end
    @(negedge clk); req_valid = '0;
    repeat (12) @(negedge clk);
    #1;
    chk("t2_all_rsp", 64'(exp_q.size()), 0);
    chk("t2_idle", 64'(busy), 0);

    // 3. backpressure: credits allow exactly DEPTH accepts
    do_reset();
    k = 0; g = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); if (c == 0) req_valid = '1; #1;
      if (req_ready != '0) begin
        g++;
        chk("t3_grant", 64'(req_ready), 64'(1 << (k % 4)));
        push_exp(k % 4); k++;
      end
    end
    chk("t3_accepts", 64'(g), 8);
    chk("t3_stalled", 64'(req_ready), 0);
    chk("t3_full_valid", 64'(rsp_valid), 1);

    // one pop at a time: each frees exactly one credit, head advances intact
    for (int p = 0; p < 2; p++) begin
      g = 0;
      @(negedge clk); rsp_ready = 1'b1; #1;
      chk("t3_no_grant_on_pop", 64'(req_ready), 0);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk); rsp_ready = 1'b0; #1;
        if (c == 0) begin
          chk("t4_head_id", 64'(rsp_id), 64'(exp_q[0].id));
          chk("t4_head_data", 64'(rsp_data), 64'(exp_q[0].data));
        end
        if (req_ready != '0) begin
          g++;
          chk("t3_pop_grant", 64'(req_ready), 64'(1 << (k % 4)));
          push_exp(k % 4); k++;
        end
      end
      chk("t3_one_per_pop", 64'(g), 1);
    end

    // 4. near-full FIFO with concurrent push and pop, then drain
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); rsp_ready = 1'b1; #1;
      if (req_ready != '0) begin
        chk("t4_grant", 64'(req_ready), 64'(1 << (k % 4)));
        push_exp(k % 4); k++;
      end
    end
    @(negedge clk); req_valid = '0;
    repeat (25) @(negedge clk);
    #1;
    chk("t4_no_loss", 64'(exp_q.size()), 0);
    chk("t4_idle", 64'(busy), 0);

    // 5. asynchronous reset with three operations in flight
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req_valid = '1; #1;
      chk("t5_grant", 64'(req_ready), 64'(1 << i));
    end
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("t5_req_ready", 64'(req_ready), 0);
    chk("t5_cc_a", 64'(cc_a != '0), 0);
    chk("t5_cc_b", 64'(cc_b != '0), 0);
    chk("t5_rsp_valid", 64'(rsp_valid), 0);
    chk("t5_rsp_id", 64'(rsp_id), 0);
    chk("t5_rsp_data", 64'(rsp_data), 0);
    chk("t5_busy", 64'(busy), 0);
    req_valid = '0;
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk("t5_discarded", 64'(rsp_valid), 0);
    end
    @(negedge clk); req_valid = '1; #1;
    chk("t5_ptr_reset", 64'(req_ready), 64'h1);
    push_exp(0);
    @(negedge clk); req_valid = '0;
    repeat (10) @(negedge clk);
    #1;
    chk("t5_post_rsp", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
